rv_if_stage: RTL and testbench

//  Instruction-fetch stage plus IF/ID pipeline register for the RV64 core. Owns the PC, issues

---
 rtl/rv_pkg.sv | 14 +
 rtl/rv_if_skid.sv | 40 ++++
 rtl/rv_if_stage.sv | 136 +++++++++++++
 tb/tb_rv_if_stage.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
// Shared RV64 core types: datapath width, canonical NOP and fetch FSM encoding.
// Pure declarations, no logic.
package rv_pkg;

    localparam int unsigned XLEN = 64;
    localparam logic [31:0] RV_NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_DROP = 2'd2
    } if_state_t;

endpackage

// File: rtl/rv_if_skid.sv
// One-entry holding buffer for a fetched {pc, instr} while decode is stalled.
// Write sets full, read or clear empties it; clear wins, data appears the cycle after the write.
module rv_if_skid #(
    parameter int unsigned W = 96
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         wr,
    input  logic         rd,
    input  logic [W-1:0] wr_dat,
    output logic         full,
    output logic [W-1:0] rd_dat
);

    logic         full_q;
    logic [W-1:0] dat_q;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            full_q <= 1'b0;
        end else if (wr) begin
            full_q <= 1'b1;
        end else if (rd) begin
            full_q <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dat_q <= '0;
        end else if (wr) begin
            dat_q <= wr_dat;
        end
    end

    assign full   = full_q;
    assign rd_dat = dat_q;

endmodule

// File: rtl/rv_if_stage.sv
// Instruction fetch with single outstanding imem request and the IF/ID register.
// Data reaches decode the cycle after rvalid; a decode stall parks it in a skid entry and blocks new requests.
module rv_if_stage
    import rv_pkg::*;
#(
    parameter int unsigned     XLEN     = rv_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            stall_i,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_ack_i,
    input  logic            imem_rvalid_i,
    input  logic [31:0]     imem_rdata_i,
    output logic            id_valid_o,
    output logic [XLEN-1:0] id_pc_o,
    output logic [31:0]     id_instr_o
);

    if_state_t       state_q, state_d;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] req_pc_q;
    logic            id_valid_q;
    logic [XLEN-1:0] id_pc_q;
    logic [31:0]     id_instr_q;

    logic            req;
    logic            fire;
    logic            deliver;
    logic            skid_full;
    logic            skid_wr;
    logic            skid_rd;
    logic [XLEN+31:0] skid_dat;
    logic [XLEN-1:0] redirect_tgt;

    assign redirect_tgt = {redirect_pc_i[XLEN-1:2], 2'b00};

    always_comb begin
        state_d = state_q;
        req     = 1'b0;
        fire    = 1'b0;
        deliver = 1'b0;
        unique case (state_q)
            S_REQ: begin
                req  = !skid_full && !rst_i;
                fire = req && imem_ack_i;
                if (fire) begin
                    state_d = redirect_i ? S_DROP : S_WAIT;
                end
            end
            S_WAIT: begin
                // A redirect in the same cycle as the response kills that response.
                deliver = imem_rvalid_i && !redirect_i;
                if (imem_rvalid_i) begin
                    state_d = S_REQ;
                end else if (redirect_i) begin
                    state_d = S_DROP;
                end
            end
            S_DROP: begin
                if (imem_rvalid_i) begin
                    state_d = S_REQ;
                end
            end
            default: state_d = S_REQ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= S_REQ;
            pc_q     <= RESET_PC;
            req_pc_q <= '0;
        end else begin
            state_q <= state_d;
            if (redirect_i) begin
                pc_q <= redirect_tgt;
            end else if (fire) begin
                pc_q <= pc_q + XLEN'(4);
            end
            if (fire) begin
                req_pc_q <= pc_q;
            end
        end
    end

    assign skid_wr = deliver && stall_i;
    assign skid_rd = skid_full && !stall_i && !redirect_i;

    rv_if_skid #(
        .W (XLEN + 32)
    ) u_skid (
        .clk    (clk_i),
        .rst    (rst_i),
        .clr    (redirect_i),
        .wr     (skid_wr),
        .rd     (skid_rd),
        .wr_dat ({req_pc_q, imem_rdata_i}),
        .full   (skid_full),
        .rd_dat (skid_dat)
    );

    // A parked entry is older than anything arriving, so it drains first.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            id_valid_q <= 1'b0;
            id_pc_q    <= '0;
            id_instr_q <= RV_NOP;
        end else if (redirect_i) begin
            id_valid_q <= 1'b0;
        end else if (!stall_i) begin
            if (skid_full) begin
                id_valid_q <= 1'b1;
                id_pc_q    <= skid_dat[XLEN+31:32];
                id_instr_q <= skid_dat[31:0];
            end else if (deliver) begin
                id_valid_q <= 1'b1;
                id_pc_q    <= req_pc_q;
                id_instr_q <= imem_rdata_i;
            end else begin
                id_valid_q <= 1'b0;
            end
        end
    end

    assign imem_req_o  = req;
    assign imem_addr_o = pc_q;
    assign id_valid_o  = id_valid_q;
    assign id_pc_o     = id_pc_q;
    assign id_instr_o  = id_instr_q;

endmodule

// File: tb/tb_rv_if_stage.sv
// Directed bench for rv_if_stage: transaction-level fetch model compared every cycle,
// plus hand-computed checks on the documented scenarios.
module tb_rv_if_stage;

    localparam logic [63:0] RST_PC = 64'h0;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [63:0] redirect_pc = '0;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_ack;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        id_valid;
    logic [63:0] id_pc;
    logic [31:0] id_instr;

    rv_if_stage #(
        .XLEN     (64),
        .RESET_PC (RST_PC)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .stall_i       (stall),
        .redirect_i    (redirect),
        .redirect_pc_i (redirect_pc),
        .imem_req_o    (imem_req),
        .imem_addr_o   (imem_addr),
        .imem_ack_i    (imem_ack),
        .imem_rvalid_i (imem_rvalid),
        .imem_rdata_i  (imem_rdata),
        .id_valid_o    (id_valid),
        .id_pc_o       (id_pc),
        .id_instr_o    (id_instr)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    bit chk_en   = 1'b0;

    // Memory: accepts whenever ack_en, answers mem_lat cycles after the ack.
    bit          ack_en   = 1'b0;
    bit          mem_keep = 1'b0;
    int          mem_lat  = 1;
    bit          mem_busy = 1'b0;
    int          mem_due  = 0;
    logic [63:0] mem_addr = '0;

    assign imem_ack = imem_req & ack_en;

    function automatic logic [31:0] instr_of(input logic [63:0] a);
        return a[31:0] ^ 32'hABCD_0000;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always begin
        @(posedge clk);
        cyc++;
        #1;
        if (mem_busy && cyc == mem_due) begin
            imem_rvalid = 1'b1;
            imem_rdata  = instr_of(mem_addr);
        end else begin
            imem_rvalid = 1'b0;
        end
    end

    // Reference model: next fetch address, one in-flight fetch that may be
    // marked killed, a queue of parked instructions, and the decode view.
    logic [63:0] m_pc          = RST_PC;
    bit          m_inflight    = 1'b0;
    bit          m_killed      = 1'b0;
    logic [63:0] m_inflight_pc = '0;
    logic [95:0] m_buf[$];
    bit          e_valid       = 1'b0;
    logic [63:0] e_pc          = '0;
    logic [31:0] e_instr       = NOP;

    always @(negedge clk) begin : model
        bit          exp_req;
        bit          dlv;
        logic [95:0] d;
        exp_req = !rst && !m_inflight && (m_buf.size() == 0);
        if (chk_en) begin
            check("imem_req", imem_req, exp_req);
            check("imem_addr", imem_addr, m_pc);
            check("id_valid", id_valid, e_valid);
            check("id_pc", id_pc, e_pc);
            check("id_instr", id_instr, e_instr);
        end
        if (rst) begin
            m_pc       = RST_PC;
            m_inflight = 1'b0;
            m_killed   = 1'b0;
            m_buf.delete();
            e_valid    = 1'b0;
            e_pc       = '0;
            e_instr    = NOP;
        end else begin
            dlv = 1'b0;
            d   = '0;
            if (m_inflight && imem_rvalid) begin
                if (!m_killed && !redirect) begin
                    dlv = 1'b1;
                    d   = {m_inflight_pc, imem_rdata};
                end
                m_inflight = 1'b0;
                m_killed   = 1'b0;
            end
            if (exp_req && ack_en) begin
                m_inflight    = 1'b1;
                m_inflight_pc = m_pc;
                m_killed      = redirect;
                m_pc          = m_pc + 64'd4;
            end
            if (redirect) begin
                if (m_inflight) m_killed = 1'b1;
                m_pc    = {redirect_pc[63:2], 2'b00};
                m_buf.delete();
                e_valid = 1'b0;
            end else if (!stall) begin
                if (m_buf.size() > 0) begin
                    d       = m_buf.pop_front();
                    e_valid = 1'b1;
                    e_pc    = d[95:32];
                    e_instr = d[31:0];
                end else if (dlv) begin
                    e_valid = 1'b1;
                    e_pc    = d[95:32];
                    e_instr = d[31:0];
                end else begin
                    e_valid = 1'b0;
                end
            end else if (dlv) begin
                m_buf.push_back(d);
            end
        end
        if (imem_rvalid) mem_busy = 1'b0;
        if (rst && !mem_keep) begin
            mem_busy = 1'b0;
        end else if (imem_req && imem_ack) begin
            mem_busy = 1'b1;
            mem_due  = cyc + mem_lat;
            mem_addr = imem_addr;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int lat, input bit aen);
        tick(1);
        rst         = 1'b1;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;
        mem_lat     = lat;
        ack_en      = aen;
        mem_keep    = 1'b0;
        tick(4);
        rst = 1'b0;
    endtask

    task automatic wait_id(input string name, input logic [63:0] pc, output int at);
        at = -1;
        for (int i = 0; i < 40 && at < 0; i++) begin
            @(negedge clk);
            if (id_valid === 1'b1) at = cyc;
        end
        if (at < 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: id_valid never rose, expected pc %h", name, pc);
        end
        check({name, "_pc"}, id_pc, pc);
        check({name, "_instr"}, id_instr, instr_of(pc));
    endtask

    // Fills the skid entry: stall from the cycle pc=4 shows until the
    // pc=8 response is parked, returning at the negedge of that full cycle.
    task automatic stall_prefix(input string name);
        int c;
        do_reset(1, 1'b1);
        wait_id({name, "_pc0"}, 64'h0, c);
        tick(2);
        stall = 1'b1;
        @(negedge clk);
        check({name, "_hold_valid"}, id_valid, 1'b1);
        check({name, "_hold_pc"}, id_pc, 64'h4);
        tick(2);
        @(negedge clk);
        check({name, "_full_noreq"}, imem_req, 1'b0);
        check({name, "_full_pc"}, id_pc, 64'h4);
        check({name, "_full_valid"}, id_valid, 1'b1);
    endtask

    initial begin
        int a, c0, c1, c2;
        tick(1);
        chk_en = 1'b1;

        // 1: back-to-back fetch with 1-cycle memory
        do_reset(1, 1'b1);
        @(negedge clk);
        a = cyc;
        check("t1_first_req", imem_req, 1'b1);
        check("t1_first_addr", imem_addr, RST_PC);
        wait_id("t1_a", 64'h0, c0);
        check("t1_instr0_lit", id_instr, 32'hABCD_0000);
        check("t1_latency", 64'(c0 - a), 64'd2);
        wait_id("t1_b", 64'h4, c1);
        check("t1_instr4_lit", id_instr, 32'hABCD_0004);
        wait_id("t1_c", 64'h8, c2);
        check("t1_gap_ab", 64'(c1 - c0), 64'd2);
        check("t1_gap_bc", 64'(c2 - c1), 64'd2);

        // 2: stall while a response lands, then release
        stall_prefix("t2");
        tick(1);
        stall = 1'b0;
        @(negedge clk);
        check("t2_drain_noreq", imem_req, 1'b0);
        check("t2_drain_pc", id_pc, 64'h4);
        @(negedge clk);
        check("t2_out_valid", id_valid, 1'b1);
        check("t2_out_pc", id_pc, 64'h8);
        check("t2_out_instr", id_instr, 32'hABCD_0008);
        check("t2_next_req", imem_req, 1'b1);
        check("t2_next_addr", imem_addr, 64'hC);

        // 4: redirect while stalled with the skid entry full
        stall_prefix("t4");
        tick(1);
        redirect    = 1'b1;
        redirect_pc = 64'h300;
        tick(1);
        redirect = 1'b0;
        @(negedge clk);
        check("t4_valid", id_valid, 1'b0);
        check("t4_req", imem_req, 1'b1);
        check("t4_addr", imem_addr, 64'h300);
        tick(1);
        stall = 1'b0;
        wait_id("t4_tgt", 64'h300, c0);

        // 3: redirect during S_WAIT, response arrives two cycles later
        do_reset(3, 1'b1);
        tick(1);
        redirect    = 1'b1;
        redirect_pc = 64'h100;
        tick(1);
        redirect = 1'b0;
        @(negedge clk);
        check("t3_valid", id_valid, 1'b0);
        check("t3_drop_noreq", imem_req, 1'b0);
        @(negedge clk);
        check("t3_drop_noreq2", imem_req, 1'b0);
        @(negedge clk);
        check("t3_req", imem_req, 1'b1);
        check("t3_addr", imem_addr, 64'h100);
        wait_id("t3_tgt", 64'h100, c0);

        // 5: target alignment and PC wrap
        do_reset(1, 1'b0);
        redirect    = 1'b1;
        redirect_pc = 64'h203;
        tick(1);
        redirect = 1'b0;
        @(negedge clk);
        check("t5_align_addr", imem_addr, 64'h200);
        check("t5_align_req", imem_req, 1'b1);
        tick(1);
        redirect    = 1'b1;
        redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
        tick(1);
        redirect = 1'b0;
        ack_en   = 1'b1;
        @(negedge clk);
        check("t5_top_addr", imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
        @(negedge clk);
        check("t5_wrap_addr", imem_addr, 64'h0);
        wait_id("t5_top", 64'hFFFF_FFFF_FFFF_FFFC, c0);
        check("t5_instr_lit", id_instr, 32'h5432_FFFC);
        wait_id("t5_zero", 64'h0, c1);

        // 6: reset in S_WAIT with the response arriving after reset
        do_reset(6, 1'b1);
        tick(1);
        rst      = 1'b1;
        ack_en   = 1'b0;
        mem_keep = 1'b1;
        @(negedge clk);
        check("t6_rst_noreq", imem_req, 1'b0);
        tick(1);
        @(negedge clk);
        check("t6_rst_valid", id_valid, 1'b0);
        check("t6_rst_pc", id_pc, 64'h0);
        check("t6_rst_instr", id_instr, NOP);
        tick(1);
        rst = 1'b0;
        @(negedge clk);
        check("t6_first_req", imem_req, 1'b1);
        check("t6_first_addr", imem_addr, RST_PC);
        repeat (4) @(negedge clk);
        check("t6_late_valid", id_valid, 1'b0);
        check("t6_late_pc", id_pc, 64'h0);
        check("t6_late_instr", id_instr, NOP);
        check("t6_late_addr", imem_addr, RST_PC);
        tick(1);
        ack_en   = 1'b1;
        mem_keep = 1'b0;
        mem_lat  = 1;
        wait_id("t6_resume", RST_PC, c0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, %0d failures so far", n_fail);
        $fatal(1, "watchdog");
    end

endmodule
